// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write arbiter: arbiter state encoding
// and the width of the burst beat counter.
package fifo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam int unsigned BeatW = 8;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority search: returns the first asserted request found
// scanning upward from ptr, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         win,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int unsigned IW = $clog2(N);

  // Scan N positions starting at ptr; the first hit wins
  always_comb begin
    win = '0;
    idx = '0;
    any = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned j;
      j = (32'(ptr) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        win[j] = 1'b1;
        idx    = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Arbitrates N requesters onto a single FIFO write port. Grants are
// combinational (zero-cycle accept); pointer/owner/state are registered.
// Define FIFO_ARB_BURST_EN to let a winner hold the port for up to
// MaxBurst consecutive beats; without it arbitration is per-beat
// round-robin and locked stays 0.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int unsigned Width    = 8,
  parameter int unsigned N        = 4,
  parameter int unsigned MaxBurst = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*Width-1:0]   din,
  input  logic                 fifo_full,
  output logic [N-1:0]         gnt,
  output logic                 fifo_wr_en,
  output logic [Width-1:0]     fifo_din,
  output logic [$clog2(N)-1:0] owner,
  output logic                 locked
);

  localparam int unsigned IW = $clog2(N);
  localparam logic [BeatW-1:0] MaxBeat = BeatW'(MaxBurst);

`ifdef FIFO_ARB_BURST_EN
  localparam logic BurstEn = 1'b1;
`else
  localparam logic BurstEn = 1'b0;
`endif

  state_t           state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    owner_q;
  logic             locked_q;
  logic [BeatW-1:0] beat_cnt;
  logic [BeatW-1:0] beat_nxt;

  logic [N-1:0]     pick_win;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] x);
    if (x == IW'(N - 1)) return '0;
    return x + IW'(1);
  endfunction

  rr_pick #(.N(N)) u_pick (
    .req (req),
    .ptr (ptr),
    .win (pick_win),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Grant: blocked by full FIFO; in LOCK only the owner may be served
  always_comb begin
    gnt = '0;
    if (!fifo_full) begin
      if (state == LOCK) gnt[owner_q] = req[owner_q];
      else               gnt = pick_win;
    end
  end

  // Route the granted slice to the FIFO; zero when nothing is granted
  always_comb begin
    fifo_din = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt[i]) fifo_din = din[i*Width +: Width];
    end
  end

  assign fifo_wr_en = |gnt;
  assign beat_nxt   = beat_cnt + BeatW'(1);
  assign owner      = owner_q;
  assign locked     = locked_q;

  // Arbiter state: everything freezes while the FIFO is full
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      owner_q  <= '0;
      locked_q <= 1'b0;
      beat_cnt <= '0;
    end else if (!fifo_full) begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            owner_q <= pick_idx;
            ptr     <= next_idx(pick_idx);
            if (BurstEn && (MaxBurst > 1)) begin
              state    <= LOCK;
              locked_q <= 1'b1;
              beat_cnt <= BeatW'(1);
            end
          end
        end
        LOCK: begin
          if (req[owner_q]) begin
            beat_cnt <= beat_nxt;
            if (beat_nxt == MaxBeat) begin
              state    <= IDLE;
              locked_q <= 1'b0;
              ptr      <= next_idx(owner_q);
            end
          end else begin
            // owner went quiet: release without granting this cycle
            state    <= IDLE;
            locked_q <= 1'b0;
            ptr      <= next_idx(owner_q);
          end
        end
        default: begin
          state    <= IDLE;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter (N=4, Width=8, MaxBurst=4).
// Directed stimulus pushes expected writes; a negedge monitor pops them.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] din;
  logic        fifo_full;
  logic [3:0]  gnt;
  logic        fifo_wr_en;
  logic [7:0]  fifo_din;
  logic [1:0]  owner;
  logic        locked;

  typedef struct packed {
    logic [3:0] g;
    logic [7:0] d;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.Width(8), .N(4), .MaxBurst(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .din        (din),
    .fifo_full  (fifo_full),
    .gnt        (gnt),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .owner      (owner),
    .locked     (locked)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] slice(input logic [3:0] g);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < 4; i++) if (g[i]) s = din[i*8 +: 8];
    return s;
  endfunction

  // One clock of stimulus; an expected write is queued when eg is nonzero
  task automatic step(input logic [3:0] r, input logic f, input logic [3:0] eg);
    req       = r;
    fifo_full = f;
    if (eg != 4'b0000) q.push_back(exp_t'{eg, slice(eg)});
    @(posedge clk);
    #1;
  endtask

  task automatic expect_reg(input string tag, input logic [1:0] own, input logic lk);
    check({tag, "_owner"}, 32'(owner), 32'(own));
    check({tag, "_locked"}, 32'(locked), 32'(lk));
  endtask

  // Monitor: every write must match the head of the scoreboard
  always @(negedge clk) begin
    if (fifo_wr_en === 1'b1) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: gnt=%b din=%0h expected no write", gnt, fifo_din);
      end else begin
        mon_e = q.pop_front();
        check("gnt", 32'(gnt), 32'(mon_e.g));
        check("fifo_din", 32'(fifo_din), 32'(mon_e.d));
      end
    end else if (rst === 1'b1) begin
      check("idle_gnt", 32'(gnt), 32'h0);
      check("idle_din", 32'(fifo_din), 32'h0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    req       = 4'b0000;
    fifo_full = 1'b0;
    din       = 32'h44332211;
    #3;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_wr_en", 32'(fifo_wr_en), 32'h0);
    check("rst_din", 32'(fifo_din), 32'h0);
    expect_reg("rst", 2'd0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;

`ifdef FIFO_ARB_BURST_EN
    // Two requesters each hold the port for four beats
    for (int i = 0; i < 8; i++) begin
      step(4'b0101, 1'b0, (i < 4) ? 4'b0001 : 4'b0100);
      expect_reg("burst", (i < 4) ? 2'd0 : 2'd2, (i == 3 || i == 7) ? 1'b0 : 1'b1);
    end
    // Owner drops after two beats: one dead cycle, then req2, then ptr=3
    step(4'b0101, 1'b0, 4'b0001); expect_reg("drop1", 2'd0, 1'b1);
    step(4'b0101, 1'b0, 4'b0001); expect_reg("drop2", 2'd0, 1'b1);
    step(4'b0100, 1'b0, 4'b0000); expect_reg("drop3", 2'd0, 1'b0);
    step(4'b0100, 1'b0, 4'b0100); expect_reg("drop4", 2'd2, 1'b1);
    step(4'b0000, 1'b0, 4'b0000); expect_reg("drop5", 2'd2, 1'b0);
    step(4'b1001, 1'b0, 4'b1000); expect_reg("ptr3", 2'd3, 1'b1);
    // Full FIFO mid-burst freezes the beat count
    step(4'b1001, 1'b0, 4'b1000); expect_reg("full0", 2'd3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(4'b1001, 1'b1, 4'b0000);
      expect_reg("full", 2'd3, 1'b1);
    end
    step(4'b1001, 1'b0, 4'b1000); expect_reg("resume3", 2'd3, 1'b1);
    step(4'b1001, 1'b0, 4'b1000); expect_reg("resume4", 2'd3, 1'b0);
    step(4'b1001, 1'b0, 4'b0001); expect_reg("next", 2'd0, 1'b1);
    // Async reset while locked to requester 3
    step(4'b1000, 1'b0, 4'b0000); expect_reg("rel", 2'd0, 1'b0);
    step(4'b1000, 1'b0, 4'b1000); expect_reg("lock3", 2'd3, 1'b1);
    req = 4'b0000;
    #2 rst = 1'b0;
    #1 expect_reg("async_rst", 2'd0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    step(4'b1000, 1'b0, 4'b1000); expect_reg("after_rst", 2'd3, 1'b1);
`else
    // All requesters busy: strict rotation
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, 1'b0, 4'b0001 << (i % 4));
      expect_reg("rr", 2'(i % 4), 1'b0);
    end
    // No requests: nothing moves
    for (int i = 0; i < 5; i++) begin
      step(4'b0000, 1'b0, 4'b0000);
      expect_reg("noreq", 2'd3, 1'b0);
    end
    // Full FIFO blocks grants and freezes the pointer
    for (int i = 0; i < 3; i++) begin
      step(4'b0101, 1'b1, 4'b0000);
      expect_reg("full", 2'd3, 1'b0);
    end
    step(4'b0101, 1'b0, 4'b0001); expect_reg("sp0", 2'd0, 1'b0);
    step(4'b0101, 1'b0, 4'b0100); expect_reg("sp1", 2'd2, 1'b0);
    step(4'b0101, 1'b0, 4'b0001); expect_reg("sp2", 2'd0, 1'b0);
    din = 32'hDEADBEEF;
    step(4'b1010, 1'b0, 4'b0010); expect_reg("odd0", 2'd1, 1'b0);
    step(4'b1010, 1'b0, 4'b1000); expect_reg("odd1", 2'd3, 1'b0);
    step(4'b1010, 1'b0, 4'b0010); expect_reg("odd2", 2'd1, 1'b0);
    step(4'b1000, 1'b0, 4'b1000); expect_reg("solo0", 2'd3, 1'b0);
    step(4'b1000, 1'b0, 4'b1000); expect_reg("solo1", 2'd3, 1'b0);
    // Async reset mid-cycle clears owner and pointer at once
    req = 4'b0000;
    #2 rst = 1'b0;
    #1 expect_reg("async_rst", 2'd0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    step(4'b1111, 1'b0, 4'b0001); expect_reg("after_rst", 2'd0, 1'b0);
    step(4'b1000, 1'b0, 4'b1000); expect_reg("after_rst2", 2'd3, 1'b0);
`endif

    step(4'b0000, 1'b0, 4'b0000);
    check("queue_drain", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
